// File: rtl/bg_block_mem_ctrl.sv
// Memory-side engine for the 16-pixel BG block cache: writes dirty pixels back as a
// masked 4-beat burst, then reads the next block and hands it to the backend.
module bg_block_mem_ctrl #(
  parameter bit SKIP_EMPTY_SAVE = 1'b1
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_blockReq,
  input  logic [1:0]   i_step,
  input  logic         i_loadEnable,
  input  logic [14:0]  i_loadAdr,
  input  logic [14:0]  i_saveAdr,
  input  logic [255:0] i_saveBlock,
  input  logic [15:0]  i_saveMask,
  output logic         o_busy,
  output logic         o_maskClear,
  output logic         o_importValid,
  output logic [255:0] o_importBlock,
  output logic         o_memCmdValid,
  input  logic         i_memCmdReady,
  output logic         o_memWrite,
  output logic [16:0]  o_memAdr,
  output logic [63:0]  o_memWData,
  output logic [7:0]   o_memBE,
  output logic         o_memWValid,
  input  logic         i_memWReady,
  input  logic         i_memRValid,
  input  logic [63:0]  i_memRData
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_CMD,
    SAVE_DATA,
    LOAD_CMD,
    LOAD_DATA,
    DONE
  } stateT;

  // Each 16-bit pixel owns two byte lanes of the 64-bit beat.
  function automatic logic [7:0] pixelBe(input logic [3:0] m);
    return {{2{m[3]}}, {2{m[2]}}, {2{m[1]}}, {2{m[0]}}};
  endfunction

  stateT          state;
  logic [1:0]     beatCnt;
  logic [1:0]     nextBeat;
  logic [255:0]   saveBlock;
  logic [15:0]    saveMask;
  logic [191:0]   asmBlock;
  logic [14:0]    loadAdr;
  logic           loadEn;
  logic           accept;
  logic           saveNeeded;

  assign nextBeat   = beatCnt + 2'd1;
  assign accept     = (state == IDLE) && i_blockReq;
  assign saveNeeded = (|i_saveMask) || !SKIP_EMPTY_SAVE;

  // NOTE: pure data registers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept && i_step[1]) begin
      saveBlock <= i_saveBlock;
      saveMask  <= i_saveMask;
    end
    if (state == LOAD_DATA && i_memRValid) begin
      case (beatCnt)
        2'd0:    asmBlock[63:0]    <= i_memRData;
        2'd1:    asmBlock[127:64]  <= i_memRData;
        2'd2:    asmBlock[191:128] <= i_memRData;
        default: ;
      endcase
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // decision in this block sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state         <= IDLE;
      beatCnt       <= 2'd0;
      loadAdr       <= '0;
      loadEn        <= 1'b0;
      o_busy        <= 1'b0;
      o_maskClear   <= 1'b0;
      o_importValid <= 1'b0;
      o_importBlock <= '0;
      o_memCmdValid <= 1'b0;
      o_memWrite    <= 1'b0;
      o_memAdr      <= '0;
      o_memWData    <= '0;
      o_memBE       <= '0;
      o_memWValid   <= 1'b0;
    end else begin
      o_maskClear   <= 1'b0;
      o_importValid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_blockReq) begin
            loadEn  <= i_loadEnable;
            loadAdr <= i_loadAdr;
            if (i_step[1]) begin
              o_maskClear <= 1'b1;
              if (saveNeeded) begin
                state         <= SAVE_CMD;
                o_busy        <= 1'b1;
                o_memCmdValid <= 1'b1;
                o_memWrite    <= 1'b1;
                o_memAdr      <= {i_saveAdr, 2'b00};
              end else if (i_loadEnable) begin
                state         <= LOAD_CMD;
                o_busy        <= 1'b1;
                o_memCmdValid <= 1'b1;
                o_memWrite    <= 1'b0;
                o_memAdr      <= {i_loadAdr, 2'b00};
              end
            end else if (i_step[0] && i_loadEnable) begin
              state         <= LOAD_CMD;
              o_busy        <= 1'b1;
              o_memCmdValid <= 1'b1;
              o_memWrite    <= 1'b0;
              o_memAdr      <= {i_loadAdr, 2'b00};
            end
          end
        end
        SAVE_CMD: begin
          if (i_memCmdReady) begin
            state         <= SAVE_DATA;
            beatCnt       <= 2'd0;
            o_memCmdValid <= 1'b0;
            o_memWValid   <= 1'b1;
            o_memWData    <= saveBlock[63:0];
            o_memBE       <= pixelBe(saveMask[3:0]);
          end
        end
        SAVE_DATA: begin
          if (i_memWReady) begin
            if (beatCnt == 2'd3) begin
              // The read is only issued here, after the last write beat has been taken.
              beatCnt     <= 2'd0;
              o_memWValid <= 1'b0;
              o_memWrite  <= 1'b0;
              if (loadEn) begin
                state         <= LOAD_CMD;
                o_memCmdValid <= 1'b1;
                o_memAdr      <= {loadAdr, 2'b00};
              end else begin
                state  <= IDLE;
                o_busy <= 1'b0;
              end
            end else begin
              beatCnt    <= nextBeat;
              o_memWData <= saveBlock[{nextBeat, 6'd0} +: 64];
              o_memBE    <= pixelBe(saveMask[{nextBeat, 2'b00} +: 4]);
            end
          end
        end
        LOAD_CMD: begin
          if (i_memCmdReady) begin
            state         <= LOAD_DATA;
            beatCnt       <= 2'd0;
            o_memCmdValid <= 1'b0;
          end
        end
        LOAD_DATA: begin
          if (i_memRValid) begin
            beatCnt <= nextBeat;
            if (beatCnt == 2'd3) begin
              state         <= DONE;
              o_importBlock <= {i_memRData, asmBlock};
              o_importValid <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
